// File: rtl/opti_out_buffer.sv
// opti_out_buffer
//   Captures one filter run into a DEPTH x DW RAM, then replays the stored
//   words in address order over a valid/ready stream.
//   A run starts with clr (FILL), ends with fill_done (DRAIN, or IDLE if the
//   run is empty) and returns to IDLE after the last word has transferred.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clr               one-cycle pulse: start a new capture run
//   wr_valid/addr/data  filter output write strobe, address, signed sample
//   fill_done         level: the filter run is complete
//   rd_ready          downstream consumer ready
//   rd_valid/data/index  output stream: stored sample and its address
//   count             words captured in the current run (0..DEPTH)
//   peak_abs          largest saturated |wr_data| of the current run
//   overrun           sticky: a write was dropped
//   busy              registered, high in FILL or DRAIN
module opti_out_buffer #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          fill_done,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_index,
  output logic [AW:0]   count,
  output logic [DW-1:0] peak_abs,
  output logic          overrun,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

  // Magnitude of a two's-complement sample; the most negative value clips
  // to the most positive one instead of wrapping back to itself.
  function automatic logic [DW-1:0] sat_abs(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    if (x[DW-1] == 1'b0) begin
      r = x;
    end else if (x == {1'b1, {(DW-1){1'b0}}}) begin
      r = {1'b0, {(DW-1){1'b1}}};
    end else begin
      r = ~x + {{(DW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t          state, state_next;
  logic            accept, drop, fire, last_xfer, rd_en;
  logic [AW:0]     count_inc, rd_next;
  logic [DW-1:0]   wr_abs, ram_q, skid_data;
  logic [AW-1:0]   pend_idx, skid_idx;
  logic            pend, skid_valid;
  logic [1:0]      occ;
  logic [DW-1:0]   mem [DEPTH];

  // Write acceptance, read issue and handshake decode.
  always_comb begin
    accept    = 1'b0;
    drop      = 1'b0;
    fire      = rd_valid & rd_ready;
    last_xfer = fire && ({1'b0, rd_index} == (count - ONE_W));
    wr_abs    = sat_abs(wr_data);
    if (clr) begin
      accept = 1'b0;
      drop   = 1'b0;
    end else if (wr_valid) begin
      if ((state == FILL) && (count < DEPTH_W)) begin
        accept = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else begin
      accept = 1'b0;
      drop   = 1'b0;
    end
    count_inc = accept ? (count + ONE_W) : count;
    // Words held or in flight (output reg, skid reg, RAM read). At most two
    // may be outstanding so a stalled consumer never loses a RAM read.
    occ   = {1'b0, rd_valid} + {1'b0, skid_valid} + {1'b0, pend};
    rd_en = (state == DRAIN) && !clr && (rd_next < count) &&
            ((occ - {1'b0, fire}) < 2'd2);
  end

  // Next-state decode; clr wins in every state.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = FILL;
    end else begin
      case (state)
        IDLE:  state_next = IDLE;
        FILL: begin
          // count_inc already includes a write arriving with fill_done.
          if (fill_done) begin
            state_next = (count_inc != {(AW+1){1'b0}}) ? DRAIN : IDLE;
          end else begin
            state_next = FILL;
          end
        end
        DRAIN: begin
          if (last_xfer) begin
            state_next = IDLE;
          end else begin
            state_next = DRAIN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Run statistics: word count, peak magnitude, sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= {(AW+1){1'b0}};
      peak_abs <= {DW{1'b0}};
      overrun  <= 1'b0;
    end else if (clr) begin
      count    <= {(AW+1){1'b0}};
      peak_abs <= {DW{1'b0}};
      overrun  <= 1'b0;
    end else begin
      count <= count_inc;
      if (accept && (wr_abs > peak_abs)) begin
        peak_abs <= wr_abs;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Sample RAM: synchronous write port, synchronous read port.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      ram_q <= mem[rd_next[AW-1:0]];
    end
  end

  // Drain pipeline: read address counter, in-flight tag, skid and output regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_next    <= {(AW+1){1'b0}};
      pend       <= 1'b0;
      pend_idx   <= {AW{1'b0}};
      skid_valid <= 1'b0;
      skid_data  <= {DW{1'b0}};
      skid_idx   <= {AW{1'b0}};
      rd_valid   <= 1'b0;
      rd_data    <= {DW{1'b0}};
      rd_index   <= {AW{1'b0}};
    end else if (clr || (state != DRAIN)) begin
      rd_next    <= {(AW+1){1'b0}};
      pend       <= 1'b0;
      skid_valid <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_next <= rd_next + ONE_W;
      end
      pend     <= rd_en;
      pend_idx <= rd_next[AW-1:0];
      if (!rd_valid || fire) begin
        // Output slot free: oldest word (skid first) moves up.
        if (skid_valid) begin
          rd_valid   <= 1'b1;
          rd_data    <= skid_data;
          rd_index   <= skid_idx;
          skid_valid <= pend;
          skid_data  <= ram_q;
          skid_idx   <= pend_idx;
        end else if (pend) begin
          rd_valid <= 1'b1;
          rd_data  <= ram_q;
          rd_index <= pend_idx;
        end else begin
          rd_valid <= 1'b0;
        end
      end else if (pend) begin
        // Consumer stalled while a read was in flight: park it.
        skid_valid <= 1'b1;
        skid_data  <= ram_q;
        skid_idx   <= pend_idx;
      end
    end
  end

endmodule
